// File: rtl/auto_bidir_counter_if.sv
// Bus between the ping-pong counter and its consumer: enable in, count (and optional segments) out.
// The seg signal exists only when SEVEN_SEG_EN is defined.
interface auto_bidir_counter_if;
  logic       enable;
  logic [3:0] q;
`ifdef SEVEN_SEG_EN
  logic [6:0] seg;

  modport master (output enable, input q, input seg);
  modport slave  (input enable, output q, output seg);
`else
  modport master (output enable, input q);
  modport slave  (input enable, output q);
`endif
endinterface

// File: rtl/auto_bidir_counter.sv
// Auto-reversing decimal counter (0..MAX_COUNT..0) stepping once per TICK_DIV enabled clocks.
// Define SEVEN_SEG_EN to add a registered 7-segment decode of the count.
module auto_bidir_counter #(
  parameter int MAX_COUNT = 9,
  parameter int TICK_DIV  = 1
) (
  input  logic                 clki,
  input  logic                 reset,
  auto_bidir_counter_if.slave  bus
);

  localparam int             PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [3:0]     MAX_Q      = 4'(MAX_COUNT);

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_t;

  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    count_q, count_d;
  dir_t          dir_q, dir_d;
  logic          step;

  // Prescaler keeps its value while enable is low so a paused tick resumes where it left off.
  always_comb begin
    presc_d = presc_q;
    step    = 1'b0;
    if (bus.enable) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        step    = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    if (step) begin
      if (count_q > MAX_Q) begin
        count_d = 4'd0;
        dir_d   = DIR_UP;
      end else if (dir_q == DIR_UP) begin
        if (count_q == MAX_Q) begin
          count_d = MAX_Q - 4'd1;
          dir_d   = DIR_DOWN;
        end else begin
          count_d = count_q + 4'd1;
        end
      end else begin
        if (count_q == 4'd0) begin
          count_d = 4'd1;
          dir_d   = DIR_UP;
        end else begin
          count_d = count_q - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clki or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      count_q <= 4'd0;
      dir_q   <= DIR_UP;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      dir_q   <= dir_d;
    end
  end

  assign bus.q = count_q;

`ifdef SEVEN_SEG_EN
  logic [6:0] seg_q;

  // Segment order is {g,f,e,d,c,b,a}; non-decimal values blank the display.
  function automatic logic [6:0] segDecode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // Decoding count_d keeps seg aligned with q on the same edge.
  always_ff @(posedge clki or negedge reset) begin
    if (!reset) begin
      seg_q <= 7'b0111111;
    end else begin
      seg_q <= segDecode(count_d);
    end
  end

  assign bus.seg = seg_q;
`endif

endmodule

// File: tb/tb_auto_bidir_counter.sv
// Directed bench for auto_bidir_counter: one DUT with TICK_DIV=1, one with TICK_DIV=4.
// Define SEVEN_SEG_EN to also check the segment decode.
module tb_auto_bidir_counter;

  logic clki;
  logic reset;
  int   errors;
  int   checks;

  auto_bidir_counter_if bus1 ();
  auto_bidir_counter_if bus4 ();

  auto_bidir_counter #(.MAX_COUNT(9), .TICK_DIV(1)) dut1 (
    .clki  (clki),
    .reset (reset),
    .bus   (bus1.slave)
  );

  auto_bidir_counter #(.MAX_COUNT(9), .TICK_DIV(4)) dut4 (
    .clki  (clki),
    .reset (reset),
    .bus   (bus4.slave)
  );

`ifdef SEVEN_SEG_EN
  logic [6:0] segTable [0:9] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                                 7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
`endif

  initial clki = 1'b0;
  always #5 clki = ~clki;

  task automatic stepEdge;
    @(posedge clki);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    bus1.enable = 1'b0;
    bus4.enable = 1'b0;
    #12;
    checks++;
    if (bus1.q !== 4'd0) begin
      errors++;
      $display("[TB] FAIL reset_q1: q=%0d expected 0", bus1.q);
    end
    checks++;
    if (bus4.q !== 4'd0) begin
      errors++;
      $display("[TB] FAIL reset_q4: q=%0d expected 0", bus4.q);
    end
`ifdef SEVEN_SEG_EN
    checks++;
    if (bus1.seg !== 7'b0111111) begin
      errors++;
      $display("[TB] FAIL reset_seg: seg=%b expected 0111111", bus1.seg);
    end
`endif
    reset = 1'b1;
  endtask

  task automatic test_pingpong;
    int expQ [20] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
    bus1.enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      stepEdge();
      checks++;
      if (bus1.q !== 4'(expQ[i])) begin
        errors++;
        $display("[TB] FAIL pingpong[%0d]: q=%0d expected %0d", i, bus1.q, expQ[i]);
      end
    end
    checks++;
    if (bus4.q !== 4'd0) begin
      errors++;
      $display("[TB] FAIL idle_q4: q=%0d expected 0", bus4.q);
    end
  endtask

  task automatic test_enable_hold;
    int expQ [8] = '{3, 4, 5, 6, 7, 8, 9, 8};
    for (int i = 0; i < 5; i++) stepEdge();
    checks++;
    if (bus1.q !== 4'd7) begin
      errors++;
      $display("[TB] FAIL hold_setup: q=%0d expected 7", bus1.q);
    end
    bus1.enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      stepEdge();
      checks++;
      if (bus1.q !== 4'd7) begin
        errors++;
        $display("[TB] FAIL hold[%0d]: q=%0d expected 7", i, bus1.q);
      end
    end
    bus1.enable = 1'b1;
    for (int i = 5; i < 8; i++) begin
      stepEdge();
      checks++;
      if (bus1.q !== 4'(expQ[i])) begin
        errors++;
        $display("[TB] FAIL resume[%0d]: q=%0d expected %0d", i, bus1.q, expQ[i]);
      end
    end
  endtask

  task automatic test_enable_toggle;
    int expQ [8] = '{7, 7, 6, 6, 5, 5, 4, 4};
    for (int i = 0; i < 8; i++) begin
      bus1.enable = (i % 2 == 0);
      stepEdge();
      checks++;
      if (bus1.q !== 4'(expQ[i])) begin
        errors++;
        $display("[TB] FAIL toggle[%0d]: q=%0d expected %0d", i, bus1.q, expQ[i]);
      end
    end
  endtask

  task automatic test_mid_reset;
    bus1.enable = 1'b1;
    for (int i = 0; i < 9; i++) stepEdge();
    checks++;
    if (bus1.q !== 4'd5) begin
      errors++;
      $display("[TB] FAIL midreset_setup: q=%0d expected 5", bus1.q);
    end
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if (bus1.q !== 4'd0) begin
      errors++;
      $display("[TB] FAIL midreset_async: q=%0d expected 0", bus1.q);
    end
`ifdef SEVEN_SEG_EN
    checks++;
    if (bus1.seg !== 7'b0111111) begin
      errors++;
      $display("[TB] FAIL midreset_seg: seg=%b expected 0111111", bus1.seg);
    end
`endif
    #2;
    reset = 1'b1;
    stepEdge();
    checks++;
    if (bus1.q !== 4'd1) begin
      errors++;
      $display("[TB] FAIL after_reset1: q=%0d expected 1", bus1.q);
    end
    stepEdge();
    checks++;
    if (bus1.q !== 4'd2) begin
      errors++;
      $display("[TB] FAIL after_reset2: q=%0d expected 2", bus1.q);
    end
  endtask

  task automatic test_prescale;
    int expRun  [8]  = '{0, 0, 0, 1, 1, 1, 1, 2};
    int expGap  [6]  = '{2, 2, 2, 2, 2, 3};
    int expMid  [6]  = '{3, 3, 3, 3, 3, 4};
    bit enGap   [6]  = '{0, 0, 1, 1, 1, 1};
    bit enMid   [6]  = '{1, 0, 0, 1, 1, 1};
    bus1.enable = 1'b0;
    bus4.enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      stepEdge();
      checks++;
      if (bus4.q !== 4'(expRun[i])) begin
        errors++;
        $display("[TB] FAIL prescale_run[%0d]: q=%0d expected %0d", i, bus4.q, expRun[i]);
      end
    end
    for (int i = 0; i < 6; i++) begin
      bus4.enable = enGap[i];
      stepEdge();
      checks++;
      if (bus4.q !== 4'(expGap[i])) begin
        errors++;
        $display("[TB] FAIL prescale_gap[%0d]: q=%0d expected %0d", i, bus4.q, expGap[i]);
      end
    end
    for (int i = 0; i < 6; i++) begin
      bus4.enable = enMid[i];
      stepEdge();
      checks++;
      if (bus4.q !== 4'(expMid[i])) begin
        errors++;
        $display("[TB] FAIL prescale_mid[%0d]: q=%0d expected %0d", i, bus4.q, expMid[i]);
      end
    end
    checks++;
    if (bus1.q !== 4'd2) begin
      errors++;
      $display("[TB] FAIL prescale_q1_held: q=%0d expected 2", bus1.q);
    end
    bus4.enable = 1'b0;
  endtask

  task automatic test_seg_decode;
    int expQ [16] = '{3, 4, 5, 6, 7, 8, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
    bus1.enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      stepEdge();
      checks++;
      if (bus1.q !== 4'(expQ[i])) begin
        errors++;
        $display("[TB] FAIL sweep_q[%0d]: q=%0d expected %0d", i, bus1.q, expQ[i]);
      end
`ifdef SEVEN_SEG_EN
      checks++;
      if (bus1.seg !== segTable[expQ[i]]) begin
        errors++;
        $display("[TB] FAIL seg[%0d]: seg=%b expected %b", expQ[i], bus1.seg, segTable[expQ[i]]);
      end
`endif
    end
    bus1.enable = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_pingpong();
    test_enable_hold();
    test_enable_toggle();
    test_mid_reset();
    test_prescale();
    test_seg_decode();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
